// File: rtl/mmio_out_port.sv
`default_nettype none
// =============================================================================
// mmio_out_port - CPU store FIFO drained onto a UART-style 8N1 line, LSB first
// Rev 1.0
// =============================================================================
module mmio_out_port #(
  parameter logic [31:0] ADDR         = 32'h0000_0000,
  parameter int          DEPTH        = 4,
  parameter int          CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int                 c_ptr_w     = $clog2(DEPTH);
  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
  localparam int                 c_baud_max  = CLKS_PER_BIT - 1;
  localparam logic [c_cnt_w-1:0] c_baud_last = c_baud_max[c_cnt_w-1:0];
  localparam logic [c_ptr_w:0]   c_full_cnt  = DEPTH[c_ptr_w:0];
  localparam logic [31:0]        c_stat_addr = ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_baud;
  logic [2:0]           r_bit_idx;
  logic [1:0]           r_byte_idx;
  logic [31:0]          r_shift;
  logic [31:0]          r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 r_overflow;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_clr_req;
  logic w_baud_done;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_full_cnt);
  assign w_push_req  = memwrite && (dataadr == ADDR);
  assign w_clr_req   = memwrite && (dataadr == c_stat_addr) && writedata[3];
  assign w_baud_done = (r_baud == c_baud_last);
  // A pop on the same edge frees the slot being written, so a full FIFO still accepts.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_done && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (r_byte_idx != 2'd3) begin
            w_state_nxt = S_START;
          end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= 2'd0;
      r_shift    <= 32'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) || w_baud_done) r_baud <= '0;
      else                                    r_baud <= r_baud + 1'b1;

      if (w_pop) begin
        r_shift    <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_byte_idx <= 2'd0;
      end else begin
        if ((r_state == S_DATA) && w_baud_done) r_shift <= r_shift >> 1;
        if ((r_state == S_STOP) && w_baud_done && (r_byte_idx != 2'd3))
          r_byte_idx <= r_byte_idx + 2'd1;
      end

      if ((r_state == S_DATA) && w_baud_done) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Set takes priority over a clear landing on the same edge.
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_clr_req) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= writedata;
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign overflow = r_overflow;
  assign readdata = (dataadr == c_stat_addr) ?
                    {28'd0, r_overflow, busy, w_full, w_empty} : 32'd0;

endmodule
`default_nettype wire
